id_ex_forward_stage: RTL
========================

// Module: id_ex_forward_stage
// PURPOSE
//  ID/EX pipeline register for the 5-stage RV32I core. It latches the decoded operands and controls.
//  It also produces the registered 2-bit forwarding selects that drive the EX-stage 4:1 operand muxes.
//  Tracks the rd of the EX/MEM slot internally, so it owns load-use stall detection and bubble insertion.
//  Upstream: decode + register file. Downstream: EX operand muxes and ALU.
// PARAMETERS
//  XLEN    32  datapath width
//  CTRL_W  16  opaque EX/MEM/WB control bundle, passed through unchanged
// PORTS
//  Timing: one clock, clk; reset rst is synchronous and active-high.
//  clk             in   1       clock, rising edge
//  rst             in   1       synchronous, active-high reset
//  hold_i          in   1       downstream hold (e.g. data memory busy): freeze all state
//  flush_i         in   1       EX branch/jump redirect: kill the instruction entering ID/EX
//  id_valid_i      in   1       ID slot holds a real instruction
//  id_pc_i         in   XLEN    PC of the ID instruction
//  id_rs1_i/rs2_i  in   5       source register indices
//  id_rs1_used_i/id_rs2_used_i  in  1  source actually read (gates hazards)
//  id_rd_i         in   5       destination register index
//  id_rs1_data_i/id_rs2_data_i  in  XLEN  register-file read data
//  id_imm_i        in   XLEN    sign-extended immediate
//  id_reg_write_i  in   1       instruction writes rd
//  id_mem_read_i   in   1       instruction is a load
//  id_use_pc_a_i   in   1       operand A = PC (AUIPC/JAL)
//  id_use_imm_b_i  in   1       operand B = immediate
//  id_ctrl_i       in   CTRL_W  passthrough controls
//  wb_reg_write_i  in   1       WB stage writes the register file this cycle
//  wb_rd_i         in   5       WB destination
//  wb_data_i       in   XLEN    WB write data
//  stall_o         out  1       combinational: hold PC and IF/ID (load-use)
//  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_o, ex_reg_write_o,
//  ex_mem_read_o, ex_ctrl_o   out  (widths as inputs)   registered ID/EX contents
//  fwd_a_sel_o     out  2       00 ex_rs1_data, 01 EX/MEM ALU result, 10 MEM/WB data, 11 ex_pc
//  fwd_b_sel_o     out  2       00 ex_rs2_data, 01 EX/MEM, 10 MEM/WB, 11 ex_imm
//  fwd_st_sel_o    out  2       store data: 00 ex_rs2_data, 01 EX/MEM, 10 MEM/WB; 11 never
// BEHAVIOUR
//  - Reset: all ex_* outputs are 0, all fwd_*_sel are 00, and the internal mem-slot valid is 0. stall_o is 0 because no valid slots exist.
//  - Latency: 1 cycle ID->EX. The selects are computed in ID and registered alongside the data.
//  - Internal mem slot {valid, rd, reg_write} takes the old ID/EX values on every non-held edge.
//  - Hazard match(rs, slot): the slot is valid, its reg_write is set, slot.rd == rs, rs != 0, and the source is used.
//  - Load-use: match(rs, ID/EX) with ex_mem_read_o set drives stall_o = 1 and loads a bubble (valid=0, reg_write=0, mem_read=0).
//  - Select for rs1/rs2, in priority order: match(ID/EX) -> 01; match(mem slot) -> 10; else 00.
//  - A is overridden to 11 by use_pc_a. B is overridden to 11 by use_imm_b. fwd_st_sel uses the rs2 result without the override.
//  - Write-through: if wb_reg_write_i is set, wb_rd_i == rs and rs != 0, latch wb_data_i instead of the register-file data.
//  - Update priority per edge: rst > hold_i > flush_i > load-use bubble > normal load.
//  - hold_i freezes ID/EX, the mem slot and the selects, and forces stall_o to 0. Upstream honours hold_i separately.
//  - flush_i while not held loads a bubble. No stall is raised for the killed instruction.
//  - A bubble or invalid entry always has fwd sel = 00 and reg_write = 0.
//  - rst asserted mid-operation clears everything on the next edge, regardless of hold_i.
//  - A bubble never matches, so a stalled instruction re-enters with the load in the mem slot and gets sel 10.
// STRUCTURE
//  - Shared package core_pkg holds:
//    - XLEN
//    - fwd_sel_e {FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_ALT=2'b11}
//    - the id_ex_t struct for the latched fields.
//  - One sub-module, fwd_sel_gen, is combinational. It takes rs, used, the two slots and the alt flag, and returns fwd_sel_e. It is instantiated 3 times.
// TESTING
//  - add x5 then add x6,x5: fwd_a_sel=01, no stall. With one unrelated instruction between them: sel=10.
//  - lw x5 then add x6,x5,x7: stall_o=1 for 1 cycle, then one bubble (ex_valid=0). The add then enters with fwd_a_sel=10.
//  - Writer to x0, then a reader of x0: sel=00 and no stall. lw x0 followed by a use of x0: no stall.
//  - WB writes x9=0xDEADBEEF while ID reads x9 (regfile value 0): ex_rs1_data_o=0xDEADBEEF and sel=00.
//  - sw x5,0(x2) right after add x5: fwd_b_sel=11, fwd_st_sel=01.
//  - hold_i for 3 cycles: all outputs stay constant. flush_i under hold is ignored. flush_i after release gives ex_valid=0.
//  - rst asserted mid-stall: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/id_ex_forward_stage_pkg.sv
// Shared core types: widths, forwarding select encoding and
// the ID/EX register layout.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_ALT   = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } slot_t;

  function automatic logic slot_hit(
    slot_t      s,
    logic [4:0] rs,
    logic       used
  );
    return used && (rs != 5'd0) && s.valid
        && s.reg_write && (s.rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_forward_stage_if.sv
// ID/EX stage bundle: decode-side inputs, WB bypass,
// pipeline controls and the registered EX-side outputs.
interface id_ex_forward_stage_if;
  import core_pkg::*;

  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [4:0]        id_rs1_i;
  logic [4:0]        id_rs2_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic [4:0]        id_rd_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;
  logic              id_use_pc_a_i;
  logic              id_use_imm_b_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              wb_reg_write_i;
  logic [4:0]        wb_rd_i;
  logic [XLEN-1:0]   wb_data_i;

  logic              stall_o;
  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [4:0]        ex_rd_o;
  logic              ex_reg_write_o;
  logic              ex_mem_read_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [1:0]        fwd_a_sel_o;
  logic [1:0]        fwd_b_sel_o;
  logic [1:0]        fwd_st_sel_o;

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_pc_i,
    input  id_rs1_i, id_rs2_i,
    input  id_rs1_used_i, id_rs2_used_i, id_rd_i,
    input  id_rs1_data_i, id_rs2_data_i, id_imm_i,
    input  id_reg_write_i, id_mem_read_i,
    input  id_use_pc_a_i, id_use_imm_b_i, id_ctrl_i,
    input  wb_reg_write_i, wb_rd_i, wb_data_i,
    output stall_o, ex_valid_o, ex_pc_o,
    output ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
    output ex_rd_o, ex_reg_write_o, ex_mem_read_o,
    output ex_ctrl_o,
    output fwd_a_sel_o, fwd_b_sel_o, fwd_st_sel_o
  );

  modport master (
    output hold_i, flush_i, id_valid_i, id_pc_i,
    output id_rs1_i, id_rs2_i,
    output id_rs1_used_i, id_rs2_used_i, id_rd_i,
    output id_rs1_data_i, id_rs2_data_i, id_imm_i,
    output id_reg_write_i, id_mem_read_i,
    output id_use_pc_a_i, id_use_imm_b_i, id_ctrl_i,
    output wb_reg_write_i, wb_rd_i, wb_data_i,
    input  stall_o, ex_valid_o, ex_pc_o,
    input  ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
    input  ex_rd_o, ex_reg_write_o, ex_mem_read_o,
    input  ex_ctrl_o,
    input  fwd_a_sel_o, fwd_b_sel_o, fwd_st_sel_o
  );

endinterface

// File: rtl/id_ex_forward_stage_fwd_sel_gen.sv
// Operand source select for one source register: nearest
// older producer wins, the alternate operand overrides.
module fwd_sel_gen
  import core_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic       i_used,
  input  slot_t      i_ex,
  input  slot_t      i_mem,
  input  logic       i_alt,
  output fwd_sel_e   o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = slot_hit(i_ex, i_rs, i_used);
  assign w_mem_hit = slot_hit(i_mem, i_rs, i_used);

  always_comb begin
    o_sel = FWD_REG;
    if (i_alt)          o_sel = FWD_ALT;
    else if (w_ex_hit)  o_sel = FWD_EXMEM;
    else if (w_mem_hit) o_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with registered forwarding selects,
// load-use stall detection and bubble insertion.
module id_ex_forward_stage
  import core_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  id_ex_forward_stage_if.slave  bus
);

  id_ex_t   r_ex;
  id_ex_t   w_ex_nxt;
  slot_t    r_mem;
  slot_t    w_ex_slot;
  fwd_sel_e r_fa, r_fb, r_fs;
  fwd_sel_e w_fa, w_fb, w_fs;
  logic     w_lu;
  logic     w_bubble;
  logic     w_wt1;
  logic     w_wt2;

  assign w_ex_slot = '{valid:     r_ex.valid,
                       rd:        r_ex.rd,
                       reg_write: r_ex.reg_write};

  // Only a load one slot ahead cannot be forwarded in time.
  assign w_lu = bus.id_valid_i && r_ex.mem_read
    && (slot_hit(w_ex_slot, bus.id_rs1_i, bus.id_rs1_used_i)
     || slot_hit(w_ex_slot, bus.id_rs2_i, bus.id_rs2_used_i));

  assign bus.stall_o = w_lu && !bus.hold_i && !bus.flush_i;

  assign w_bubble = bus.flush_i || w_lu || !bus.id_valid_i;

  assign w_wt1 = bus.wb_reg_write_i && (bus.id_rs1_i != 5'd0)
              && (bus.wb_rd_i == bus.id_rs1_i);
  assign w_wt2 = bus.wb_reg_write_i && (bus.id_rs2_i != 5'd0)
              && (bus.wb_rd_i == bus.id_rs2_i);

  fwd_sel_gen u_sel_a (
    .i_rs   (bus.id_rs1_i),
    .i_used (bus.id_rs1_used_i),
    .i_ex   (w_ex_slot),
    .i_mem  (r_mem),
    .i_alt  (bus.id_use_pc_a_i),
    .o_sel  (w_fa)
  );

  fwd_sel_gen u_sel_b (
    .i_rs   (bus.id_rs2_i),
    .i_used (bus.id_rs2_used_i),
    .i_ex   (w_ex_slot),
    .i_mem  (r_mem),
    .i_alt  (bus.id_use_imm_b_i),
    .o_sel  (w_fb)
  );

  fwd_sel_gen u_sel_st (
    .i_rs   (bus.id_rs2_i),
    .i_used (bus.id_rs2_used_i),
    .i_ex   (w_ex_slot),
    .i_mem  (r_mem),
    .i_alt  (1'b0),
    .o_sel  (w_fs)
  );

  always_comb begin
    w_ex_nxt = '0;
    if (!w_bubble) begin
      w_ex_nxt.valid     = 1'b1;
      w_ex_nxt.pc        = bus.id_pc_i;
      w_ex_nxt.rs1_data  = w_wt1 ? bus.wb_data_i
                                 : bus.id_rs1_data_i;
      w_ex_nxt.rs2_data  = w_wt2 ? bus.wb_data_i
                                 : bus.id_rs2_data_i;
      w_ex_nxt.imm       = bus.id_imm_i;
      w_ex_nxt.rd        = bus.id_rd_i;
      w_ex_nxt.reg_write = bus.id_reg_write_i;
      w_ex_nxt.mem_read  = bus.id_mem_read_i;
      w_ex_nxt.ctrl      = bus.id_ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_fa  <= FWD_REG;
      r_fb  <= FWD_REG;
      r_fs  <= FWD_REG;
    end else if (!bus.hold_i) begin
      r_mem <= w_ex_slot;
      r_ex  <= w_ex_nxt;
      r_fa  <= w_bubble ? FWD_REG : w_fa;
      r_fb  <= w_bubble ? FWD_REG : w_fb;
      r_fs  <= w_bubble ? FWD_REG : w_fs;
    end
  end

  assign bus.ex_valid_o     = r_ex.valid;
  assign bus.ex_pc_o        = r_ex.pc;
  assign bus.ex_rs1_data_o  = r_ex.rs1_data;
  assign bus.ex_rs2_data_o  = r_ex.rs2_data;
  assign bus.ex_imm_o       = r_ex.imm;
  assign bus.ex_rd_o        = r_ex.rd;
  assign bus.ex_reg_write_o = r_ex.reg_write;
  assign bus.ex_mem_read_o  = r_ex.mem_read;
  assign bus.ex_ctrl_o      = r_ex.ctrl;
  assign bus.fwd_a_sel_o    = r_fa;
  assign bus.fwd_b_sel_o    = r_fb;
  assign bus.fwd_st_sel_o   = r_fs;

endmodule
